// File: rtl/sram_bridge_16x2.sv
// sram_bridge_16x2: 32-bit word port onto a 16-bit asynchronous SRAM, two half-word phases per access.
module sram_bridge_16x2 #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [17:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_bmask,
  input  logic        i_wren,
  input  logic        i_rden,
  output logic [31:0] o_rdata,
  output logic        o_ack,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] haddr_q, haddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic        phase, hi, last, lo_in, hi_in, hi_need;
  logic        unused_addr_lsbs;
  assign unused_addr_lsbs = ^i_addr[1:0];
  assign phase   = (state_q == LO) || (state_q == HI);
  assign hi      = state_q == HI;
  assign last    = cnt_q == 3'(ACCESS_CYCLES - 1);
  // reads always use both phases; writes skip a phase with no enabled bytes
  assign lo_in   = ~i_wren | (|i_bmask[1:0]);
  assign hi_in   = ~i_wren | (|i_bmask[3:2]);
  assign hi_need = ~wr_q | (|mask_q[3:2]);
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    haddr_d     = haddr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    wr_d        = wr_q;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    case (state_q)
      IDLE: if (i_wren | i_rden) begin
        haddr_d     = i_addr[17:2];
        wdata_d     = i_wdata;
        mask_d      = i_bmask;
        wr_d        = i_wren;
        state_d     = lo_in ? LO : hi_in ? HI : DONE;
        sram_addr_d = (lo_in | hi_in) ? {1'b0, i_addr[17:2], ~lo_in} : sram_addr_q;
      end
      LO: begin
        cnt_d = last ? '0 : cnt_q + 3'd1;
        if (last) begin
          rdata_d[15:0] = wr_q ? rdata_q[15:0] : SRAM_DQ;
          state_d       = hi_need ? HI : DONE;
          sram_addr_d   = hi_need ? {1'b0, haddr_q, 1'b1} : sram_addr_q;
        end
      end
      HI: begin
        cnt_d = last ? '0 : cnt_q + 3'd1;
        if (last) begin
          rdata_d[31:16] = wr_q ? rdata_q[31:16] : SRAM_DQ;
          state_d        = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      haddr_q     <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      wr_q        <= 1'b0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      haddr_q     <= haddr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      wr_q        <= wr_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
    end
  end
  assign o_rdata   = rdata_q;
  assign o_ack     = state_q == DONE;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_CE_N = ~phase;
  assign SRAM_OE_N = ~(phase & ~wr_q);
  // WE_N rises one cycle before the phase ends so data is held past the write edge
  assign SRAM_WE_N = ~(phase & wr_q & ~last);
  assign SRAM_LB_N = ~(phase & (~wr_q | (hi ? mask_q[2] : mask_q[0])));
  assign SRAM_UB_N = ~(phase & (~wr_q | (hi ? mask_q[3] : mask_q[1])));
  assign SRAM_DQ   = (phase & wr_q) ? (hi ? wdata_q[31:16] : wdata_q[15:0]) : 16'hzzzz;
endmodule

// File: tb/tb_sram_bridge_16x2.sv
// tb_sram_bridge_16x2: table-driven transactions against an SRAM model, plus reset and back-to-back sequences.
module tb_sram_bridge_16x2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [17:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  mask = '0;
  logic        wren = 1'b0, rden = 1'b0, rden4 = 1'b0, probe = 1'b0;
  logic [31:0] rdata, rdata4;
  logic        ack, ack4, ce, we, oe, lb, ub, ce4, we4, oe4, lb4, ub4;
  logic [17:0] sa, sa4;
  wire  [15:0] dq, dq4;
  sram_bridge_16x2 #(.ACCESS_CYCLES(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_wdata(wdata), .i_bmask(mask),
    .i_wren(wren), .i_rden(rden), .o_rdata(rdata), .o_ack(ack), .SRAM_ADDR(sa), .SRAM_DQ(dq),
    .SRAM_CE_N(ce), .SRAM_WE_N(we), .SRAM_OE_N(oe), .SRAM_LB_N(lb), .SRAM_UB_N(ub));
  sram_bridge_16x2 #(.ACCESS_CYCLES(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_wdata(wdata), .i_bmask(mask),
    .i_wren(1'b0), .i_rden(rden4), .o_rdata(rdata4), .o_ack(ack4), .SRAM_ADDR(sa4), .SRAM_DQ(dq4),
    .SRAM_CE_N(ce4), .SRAM_WE_N(we4), .SRAM_OE_N(oe4), .SRAM_LB_N(lb4), .SRAM_UB_N(ub4));
  logic [15:0] mem [256] = '{default: 16'h0000};
  assign dq  = (!ce && !oe && we) ? mem[sa[7:0]] : probe ? 16'hC3C3 : 16'hzzzz;
  assign dq4 = (!ce4 && !oe4) ? (sa4[15:0] ^ 16'h5A5A) : 16'hzzzz;
  typedef struct packed {logic [17:0] a; logic [15:0] d; logic [1:0] bl;} tr_t;
  tr_t trace[$];
  int nce = 0, nack = 0;
  always @(posedge clk) begin
    if (!ce) nce++;
    if (ack) nack++;
    if (!ce && !we) begin
      trace.push_back('{sa, dq, {ub, lb}});
      if (!lb) mem[sa[7:0]][7:0] <= dq[7:0];
      if (!ub) mem[sa[7:0]][15:8] <= dq[15:8];
    end
  end
  typedef struct {logic [31:0] rd; int lat;} exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic txn(input string tag, input logic w, input logic r, input logic [17:0] a,
                     input logic [31:0] d, input logic [3:0] m, input logic [31:0] erd, input int elat,
                     output int t0, output int c0);
    int lat;
    exp_t e;
    @(negedge clk);
    wren = w; rden = r; addr = a; wdata = d; mask = m;
    t0 = trace.size(); c0 = nce;
    sb.push_back('{erd, elat});
    @(posedge clk); #1;
    wren = 1'b0; rden = 1'b0; lat = 1;
    while (!ack && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    chk({tag, "_ack_seen"}, 64'(ack), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'(e.lat));
    chk({tag, "_rdata"}, 64'(rdata), 64'(e.rd));
    @(posedge clk); #1;
    chk({tag, "_ack_pulse"}, 64'(ack), 64'd0);
  endtask
  typedef struct {
    logic wr, rd; logic [17:0] a; logic [31:0] wd; logic [3:0] m; logic [31:0] erd;
    int lat, nce, nwe; logic [17:0] a0, a1; logic [15:0] d0, d1; logic [1:0] bl0;
  } vec_t;
  vec_t v[12];
  initial begin
    int t0, c0, n, a0;
    string tag;
    v[0]  = '{1, 0, 18'h10, 32'hA5A51234, 4'hF, 32'h0,        5, 4, 2, 18'h008, 18'h009, 16'h1234, 16'hA5A5, 2'b00};
    v[1]  = '{0, 1, 18'h10, 32'h0,        4'h0, 32'hA5A51234, 5, 4, 0, 18'h0,   18'h0,   16'h0,    16'h0,    2'b00};
    v[2]  = '{1, 0, 18'h10, 32'hDEADBEEF, 4'hC, 32'hA5A51234, 3, 2, 1, 18'h009, 18'h0,   16'hDEAD, 16'h0,    2'b00};
    v[3]  = '{0, 1, 18'h10, 32'h0,        4'h0, 32'hDEAD1234, 5, 4, 0, 18'h0,   18'h0,   16'h0,    16'h0,    2'b00};
    v[4]  = '{1, 0, 18'h10, 32'h0,        4'h0, 32'hDEAD1234, 1, 0, 0, 18'h0,   18'h0,   16'h0,    16'h0,    2'b00};
    v[5]  = '{1, 0, 18'h20, 32'h11223344, 4'h5, 32'hDEAD1234, 5, 4, 2, 18'h010, 18'h011, 16'h3344, 16'h1122, 2'b10};
    v[6]  = '{0, 1, 18'h20, 32'h0,        4'h0, 32'h00220044, 5, 4, 0, 18'h0,   18'h0,   16'h0,    16'h0,    2'b00};
    v[7]  = '{1, 1, 18'h24, 32'hCAFEF00D, 4'hF, 32'h00220044, 5, 4, 2, 18'h012, 18'h013, 16'hF00D, 16'hCAFE, 2'b00};
    v[8]  = '{0, 1, 18'h24, 32'h0,        4'h0, 32'hCAFEF00D, 5, 4, 0, 18'h0,   18'h0,   16'h0,    16'h0,    2'b00};
    v[9]  = '{1, 0, 18'h30, 32'h87654321, 4'h3, 32'hCAFEF00D, 3, 2, 1, 18'h018, 18'h0,   16'h4321, 16'h0,    2'b00};
    v[10] = '{0, 1, 18'h32, 32'h0,        4'h0, 32'h00004321, 5, 4, 0, 18'h0,   18'h0,   16'h0,    16'h0,    2'b00};
    v[11] = '{0, 1, 18'h10, 32'h0,        4'h0, 32'hDEAD1234, 5, 4, 0, 18'h0,   18'h0,   16'h0,    16'h0,    2'b00};
    #1;
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_addr", 64'(sa), 64'd0);
    chk("rst_ctrl", 64'({ce, we, oe, lb, ub}), 64'h1F);
    #11 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tag = $sformatf("v%0d", i);
      txn(tag, v[i].wr, v[i].rd, v[i].a, v[i].wd, v[i].m, v[i].erd, v[i].lat, t0, c0);
      chk({tag, "_ce_cycles"}, 64'(nce - c0), 64'(v[i].nce));
      chk({tag, "_we_cycles"}, 64'(trace.size() - t0), 64'(v[i].nwe));
      if (v[i].nwe > 0 && trace.size() > t0) begin
        chk({tag, "_lo_addr"}, 64'(trace[t0].a), 64'(v[i].a0));
        chk({tag, "_lo_dq"}, 64'(trace[t0].d), 64'(v[i].d0));
        chk({tag, "_lo_ublb"}, 64'(trace[t0].bl), 64'(v[i].bl0));
      end
      if (v[i].nwe > 1 && trace.size() > t0 + 1) begin
        chk({tag, "_hi_addr"}, 64'(trace[t0+1].a), 64'(v[i].a1));
        chk({tag, "_hi_dq"}, 64'(trace[t0+1].d), 64'(v[i].d1));
      end
    end
    // reset landing in the HI phase of a write aborts it
    @(negedge clk);
    wren = 1'b1; addr = 18'h40; wdata = 32'h99998888; mask = 4'hF; a0 = nack;
    @(posedge clk); #1;
    wren = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("pre_rst_hi", 64'({sa, ce, we}), 64'({18'h021, 1'b0, 1'b0}));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", 64'({ce, we, oe, lb, ub}), 64'h1F);
    chk("rst_mid_ack", 64'(ack), 64'd0);
    chk("rst_mid_rdata", 64'(rdata), 64'd0);
    chk("rst_mid_addr", 64'(sa), 64'd0);
    probe = 1'b1;
    #1;
    chk("rst_mid_dq_z", 64'(dq), 64'hC3C3);
    probe = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk("rst_no_ack", 64'(nack - a0), 64'd0);
    chk("rst_lo_written", 64'(mem[8'h20]), 64'h8888);
    chk("rst_hi_skipped", 64'(mem[8'h21]), 64'h0);
    txn("post_rst", 1'b0, 1'b1, 18'h40, 32'h0, 4'h0, 32'h00008888, 5, t0, c0);
    // back-to-back reads on the 4-cycle instance with the request held high
    @(negedge clk);
    addr = 18'h100; rden4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      sb.push_back('{32'h5ADB5ADA, 9});
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!ack4 && n < 40);
      e = sb.pop_front();
      chk($sformatf("b2b%0d_latency", k), 64'(n), 64'(e.lat));
      chk($sformatf("b2b%0d_rdata", k), 64'(rdata4), 64'(e.rd));
      @(posedge clk); #1;
      chk($sformatf("b2b%0d_idle", k), 64'({ack4, ce4}), 64'b01);
    end
    @(negedge clk) rden4 = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
